// File: rtl/bno085_pkg.sv
// Shared report IDs, parser state encoding and the report body-length lookup
// for the BNO085 SHTP report parser.
package bno085_pkg;

  localparam logic [7:0] RPT_GYRO_CAL  = 8'h02;
  localparam logic [7:0] RPT_ROT_VEC   = 8'h05;
  localparam logic [7:0] RPT_GAME_ROT  = 8'h08;
  localparam logic [7:0] RPT_TIMESTAMP = 8'hFB;

  localparam logic [7:0]  SENSOR_CHANNEL_DEFAULT = 8'd3;
  localparam logic [14:0] HDR_LEN                = 15'd4;
  localparam int          STAGE_BYTES            = 14;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RPT_ID,
    RPT_BODY,
    SKIP
  } state_t;

  // Bytes following the report ID; zero marks an ID this parser does not know.
  function automatic logic [3:0] body_len(input logic [7:0] id);
    case (id)
      RPT_TIMESTAMP: body_len = 4'd4;
      RPT_ROT_VEC:   body_len = 4'd13;
      RPT_GAME_ROT:  body_len = 4'd11;
      RPT_GYRO_CAL:  body_len = 4'd9;
      default:       body_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/bno085_report_parser.sv
// Walks the SHTP byte stream from the BNO085, validates headers and report
// lengths, and commits quaternion / gyro reports atomically to held outputs.
module bno085_report_parser
  import bno085_pkg::*;
#(
  parameter logic [7:0] SENSOR_CHANNEL = SENSOR_CHANNEL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               rx_first,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic               quat_valid,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               gyro_valid,
  output logic [7:0]         drop_count
);

  state_t      state;
  logic [1:0]  hdr_idx;
  logic [7:0]  len_lsb;
  logic [7:0]  len_msb;
  logic [7:0]  chan;
  logic [14:0] rem;
  logic [7:0]  rpt_id;
  logic [3:0]  blen;
  logic [3:0]  body_idx;
  logic [7:0]  stage [STAGE_BYTES];

  logic [14:0] len;
  logic [14:0] rem_dec;
  logic [3:0]  id_len;
  logic [7:0]  drop_inc;
  logic [7:0]  body_view [STAGE_BYTES];

  assign len      = {len_msb[6:0], len_lsb};
  assign rem_dec  = rem - 15'd1;
  assign id_len   = body_len(rx_byte);
  assign drop_inc = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;

  // The last body byte is still on rx_byte when the report commits, so the
  // commit reads the staged bytes with that byte overlaid at its index.
  always_comb begin
    // NOTE: the whole array gets a default before the indexed overlay, so no
    // path leaves body_view unassigned and no latch is inferred.
    body_view           = stage;
    body_view[body_idx] = rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the value from before the edge regardless of statement order.
      state      <= IDLE;
      hdr_idx    <= 2'd0;
      len_lsb    <= 8'd0;
      len_msb    <= 8'd0;
      chan       <= 8'd0;
      rem        <= 15'd0;
      rpt_id     <= 8'd0;
      blen       <= 4'd0;
      body_idx   <= 4'd0;
      quat_w     <= 16'sd0;
      quat_x     <= 16'sd0;
      quat_y     <= 16'sd0;
      quat_z     <= 16'sd0;
      quat_valid <= 1'b0;
      gyro_x     <= 16'sd0;
      gyro_y     <= 16'sd0;
      gyro_z     <= 16'sd0;
      gyro_valid <= 1'b0;
      drop_count <= 8'd0;
      // NOTE: the staging buffer is small and must read as zero after reset,
      // so it is cleared here rather than left as an unreset memory.
      for (int i = 0; i < STAGE_BYTES; i++) stage[i] <= 8'd0;
    end else begin
      quat_valid <= 1'b0;
      gyro_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_first) begin
          // A new packet always wins; only a half-received report counts as a drop.
          if (state == RPT_BODY) drop_count <= drop_inc;
          len_lsb <= rx_byte;
          hdr_idx <= 2'd1;
          state   <= HDR;
        end else begin
          case (state)
            IDLE: ;
            HDR: begin
              hdr_idx <= hdr_idx + 2'd1;
              case (hdr_idx)
                2'd1:    len_msb <= rx_byte;
                2'd2:    chan    <= rx_byte;
                default: begin
                  rem <= (len > HDR_LEN) ? len - HDR_LEN : 15'd0;
                  if (len <= HDR_LEN) begin
                    state <= IDLE;
                  end else if (len_msb[7]) begin
                    state      <= SKIP;
                    drop_count <= drop_inc;
                  end else if (chan != SENSOR_CHANNEL) begin
                    state <= SKIP;
                  end else begin
                    state <= RPT_ID;
                  end
                end
              endcase
            end
            RPT_ID: begin
              rem      <= rem_dec;
              rpt_id   <= rx_byte;
              blen     <= id_len;
              body_idx <= 4'd0;
              if (id_len == 4'd0 || {11'd0, id_len} > rem_dec) begin
                drop_count <= drop_inc;
                state      <= (rem_dec == 15'd0) ? IDLE : SKIP;
              end else begin
                state <= RPT_BODY;
              end
            end
            RPT_BODY: begin
              rem             <= rem_dec;
              stage[body_idx] <= rx_byte;
              body_idx        <= body_idx + 4'd1;
              if (body_idx == blen - 4'd1) begin
                // Body layout: seq, status, delay, then little-endian fields.
                case (rpt_id)
                  RPT_ROT_VEC, RPT_GAME_ROT: begin
                    quat_x     <= {body_view[4],  body_view[3]};
                    quat_y     <= {body_view[6],  body_view[5]};
                    quat_z     <= {body_view[8],  body_view[7]};
                    quat_w     <= {body_view[10], body_view[9]};
                    quat_valid <= 1'b1;
                  end
                  RPT_GYRO_CAL: begin
                    gyro_x     <= {body_view[4], body_view[3]};
                    gyro_y     <= {body_view[6], body_view[5]};
                    gyro_z     <= {body_view[8], body_view[7]};
                    gyro_valid <= 1'b1;
                  end
                  default: ;
                endcase
                state <= (rem_dec == 15'd0) ? IDLE : RPT_ID;
              end
            end
            SKIP: begin
              rem <= rem_dec;
              if (rem_dec == 15'd0) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bno085_report_parser.sv
// Bench for bno085_report_parser: table vectors, hand-written corner cases and
// randomized packets checked against a packet-level reference model.
module tb_bno085_report_parser;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_byte = 8'd0;
  logic               rx_valid = 1'b0;
  logic               rx_first = 1'b0;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z;
  logic signed [15:0] gyro_x, gyro_y, gyro_z;
  logic               quat_valid, gyro_valid;
  logic [7:0]         drop_count;

  always #5 clk = ~clk;

  bno085_report_parser #(.SENSOR_CHANNEL(8'd3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_first   (rx_first),
    .quat_w     (quat_w),
    .quat_x     (quat_x),
    .quat_y     (quat_y),
    .quat_z     (quat_z),
    .quat_valid (quat_valid),
    .gyro_x     (gyro_x),
    .gyro_y     (gyro_y),
    .gyro_z     (gyro_z),
    .gyro_valid (gyro_valid),
    .drop_count (drop_count)
  );

  typedef struct {
    string       name;
    logic [7:0]  id;
    logic [7:0]  chan;
    logic        cont;
    int          trunc;
    logic [15:0] f0, f1, f2, f3;
    int          n_quat, n_gyro, n_drop;
    logic [63:0] exp_q;   // {w, x, y, z}
    logic [47:0] exp_g;   // {x, y, z}
  } vec_t;

  vec_t vecs [12];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_accept_cyc = 0;
  int gap_max = 0;
  int hold_err = 0;
  int exp_drop = 0;
  logic [63:0] cur_q = 64'd0;
  logic [47:0] cur_g = 48'd0;
  logic [7:0]  seq_ctr = 8'd0;

  logic [7:0]  pkt [$];
  logic [7:0]  tx [$];
  logic [63:0] got_q [$];
  logic [47:0] got_g [$];
  int          got_q_cyc [$];
  int          got_g_cyc [$];
  logic [63:0] exp_q [$];
  logic [47:0] exp_g [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every pulse and flags any output change that arrives without one.
  logic        mon_prev_ok = 1'b0;
  logic [63:0] q_prev = 64'd0;
  logic [47:0] g_prev = 48'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_ok = 1'b0;
    end else begin
      if (quat_valid) begin
        got_q.push_back({quat_w, quat_x, quat_y, quat_z});
        got_q_cyc.push_back(cyc);
      end
      if (gyro_valid) begin
        got_g.push_back({gyro_x, gyro_y, gyro_z});
        got_g_cyc.push_back(cyc);
      end
      if (mon_prev_ok && !quat_valid && ({quat_w, quat_x, quat_y, quat_z} != q_prev)) hold_err++;
      if (mon_prev_ok && !gyro_valid && ({gyro_x, gyro_y, gyro_z} != g_prev)) hold_err++;
      q_prev = {quat_w, quat_x, quat_y, quat_z};
      g_prev = {gyro_x, gyro_y, gyro_z};
      mon_prev_ok = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int spec_body_len(input logic [7:0] id);
    case (id)
      8'hFB:   return 4;
      8'h05:   return 13;
      8'h08:   return 11;
      8'h02:   return 9;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  function automatic logic [15:0] le16(input int p);
    return {tx[p+1], tx[p]};
  endfunction

  // Appends one report (ID + body) to pkt; unknown IDs get a 9-byte filler body.
  task automatic add_report(input logic [7:0] id, input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
    logic [7:0] b [13];
    int n;
    b[0] = 8'h01; b[1] = 8'h03; b[2] = 8'h00;
    b[3] = f0[7:0]; b[4]  = f0[15:8];
    b[5] = f1[7:0]; b[6]  = f1[15:8];
    b[7] = f2[7:0]; b[8]  = f2[15:8];
    b[9] = f3[7:0]; b[10] = f3[15:8];
    b[11] = 8'h5A;  b[12] = 8'hA5;
    n = spec_body_len(id);
    if (n == 0) n = 9;
    pkt.push_back(id);
    for (int i = 0; i < n; i++) pkt.push_back(b[i]);
  endtask

  // Header + payload; a nonzero trunc shortens the declared length and the bytes sent.
  task automatic build_tx(input logic [7:0] chan, input logic cont, input int trunc);
    int len;
    logic [14:0] l15;
    len = pkt.size() + 4 - trunc;
    l15 = 15'(len);
    tx.delete();
    tx.push_back(l15[7:0]);
    tx.push_back({cont, l15[14:8]});
    tx.push_back(chan);
    tx.push_back(seq_ctr);
    seq_ctr = seq_ctr + 8'd1;
    for (int i = 0; i < len - 4; i++) tx.push_back(pkt[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first);
    int g;
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_first = first;
    @(posedge clk);
    #1;
    last_accept_cyc = cyc;
    rx_valid = 1'b0;
    rx_first = 1'b0;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic send_tx(input int count);
    for (int i = 0; i < count; i++) send_byte(tx[i], (i == 0));
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_events();
    got_q.delete(); got_g.delete(); got_q_cyc.delete(); got_g_cyc.delete();
    exp_q.delete(); exp_g.delete();
  endtask

  // Reference: reads the whole packet with index arithmetic and lists what must commit.
  task automatic model_packet();
    logic [7:0] b0, b1;
    int len, pos, n;
    b0 = tx[0];
    b1 = tx[1];
    len = int'({b1[6:0], b0});
    if (len <= 4) return;
    if (b1[7]) begin exp_drop++; return; end
    if (tx[2] != 8'd3) return;
    pos = 4;
    while (pos < len) begin
      n = spec_body_len(tx[pos]);
      if (n == 0 || pos + 1 + n > len) begin exp_drop++; return; end
      if (tx[pos] == 8'h05 || tx[pos] == 8'h08)
        exp_q.push_back({le16(pos + 10), le16(pos + 4), le16(pos + 6), le16(pos + 8)});
      if (tx[pos] == 8'h02)
        exp_g.push_back({le16(pos + 4), le16(pos + 6), le16(pos + 8)});
      pos += 1 + n;
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nquat"}, 64'(got_q.size()), 64'(exp_q.size()));
    check({tag, "_ngyro"}, 64'(got_g.size()), 64'(exp_g.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check({tag, "_quat"}, got_q[i], exp_q[i]);
    for (int i = 0; i < got_g.size() && i < exp_g.size(); i++) check({tag, "_gyro"}, 64'(got_g[i]), 64'(exp_g[i]));
    check({tag, "_drop"}, 64'(drop_count), 64'(sat8(exp_drop)));
  endtask

  initial begin
    vecs[0]  = '{"rot_vec",     8'h05, 8'd3, 1'b0, 0,  16'h1000, 16'hF000, 16'h0000, 16'h3000, 1, 0, 0, 64'h3000_1000_F000_0000, 48'h0};
    vecs[1]  = '{"game_rot",    8'h08, 8'd3, 1'b0, 0,  16'h0123, 16'hFEDC, 16'h7FFF, 16'h8001, 1, 0, 0, 64'h8001_0123_FEDC_7FFF, 48'h0};
    vecs[2]  = '{"gyro",        8'h02, 8'd3, 1'b0, 0,  16'h0200, 16'hFE00, 16'h0001, 16'hAAAA, 0, 1, 0, 64'h0, 48'h0200_FE00_0001};
    vecs[3]  = '{"timestamp",   8'hFB, 8'd3, 1'b0, 0,  16'h5555, 16'h5555, 16'h5555, 16'h5555, 0, 0, 0, 64'h0, 48'h0};
    vecs[4]  = '{"unknown_id",  8'h11, 8'd3, 1'b0, 0,  16'h6666, 16'h6666, 16'h6666, 16'h6666, 0, 0, 1, 64'h0, 48'h0};
    vecs[5]  = '{"rot_recover", 8'h05, 8'd3, 1'b0, 0,  16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, 0, 0, 64'h0004_0001_0002_0003, 48'h0};
    vecs[6]  = '{"wrong_chan",  8'h05, 8'd2, 1'b0, 0,  16'h7777, 16'h7777, 16'h7777, 16'h7777, 0, 0, 0, 64'h0, 48'h0};
    vecs[7]  = '{"cont_bit",    8'h05, 8'd3, 1'b1, 0,  16'h7777, 16'h7777, 16'h7777, 16'h7777, 0, 0, 1, 64'h0, 48'h0};
    vecs[8]  = '{"trunc_len10", 8'h05, 8'd3, 1'b0, 8,  16'h7777, 16'h7777, 16'h7777, 16'h7777, 0, 0, 1, 64'h0, 48'h0};
    vecs[9]  = '{"gyro_short",  8'h02, 8'd3, 1'b0, 1,  16'h7777, 16'h7777, 16'h7777, 16'h7777, 0, 0, 1, 64'h0, 48'h0};
    vecs[10] = '{"hdr_only",    8'h02, 8'd3, 1'b0, 10, 16'h7777, 16'h7777, 16'h7777, 16'h7777, 0, 0, 0, 64'h0, 48'h0};
    vecs[11] = '{"gyro_neg",    8'h02, 8'd3, 1'b0, 0,  16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 0, 1, 0, 64'h0, 48'h8000_7FFF_FFFF};

    // Reset with traffic present: nothing may be accepted while rst_n is low.
    rx_byte = 8'h12; rx_valid = 1'b1; rx_first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_first = 1'b0; rst_n = 1'b1;
    settle();
    check("rst_quat",  {quat_w, quat_x, quat_y, quat_z}, 64'd0);
    check("rst_gyro",  64'({gyro_x, gyro_y, gyro_z}), 64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    check("rst_pulse", 64'({quat_valid, gyro_valid}), 64'd0);

    // Table vectors: one report per packet with expectations written in the table.
    gap_max = 1;
    foreach (vecs[i]) begin
      clear_events();
      pkt.delete();
      add_report(vecs[i].id, vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].f3);
      build_tx(vecs[i].chan, vecs[i].cont, vecs[i].trunc);
      send_tx(tx.size());
      settle();
      exp_drop += vecs[i].n_drop;
      if (vecs[i].n_quat == 1) begin exp_q.push_back(vecs[i].exp_q); cur_q = vecs[i].exp_q; end
      if (vecs[i].n_gyro == 1) begin exp_g.push_back(vecs[i].exp_g); cur_g = vecs[i].exp_g; end
      compare_events(vecs[i].name);
      check({vecs[i].name, "_qhold"}, {quat_w, quat_x, quat_y, quat_z}, cur_q);
      check({vecs[i].name, "_ghold"}, 64'({gyro_x, gyro_y, gyro_z}), 64'(cur_g));
      if (vecs[i].n_quat == 1 && got_q_cyc.size() > 0)
        check({vecs[i].name, "_latency"}, 64'(got_q_cyc[0]), 64'(last_accept_cyc));
      if (vecs[i].n_gyro == 1 && got_g_cyc.size() > 0)
        check({vecs[i].name, "_latency"}, 64'(got_g_cyc[0]), 64'(last_accept_cyc));
    end

    // Timestamp then gyro in one 19-byte packet.
    clear_events();
    pkt.delete();
    add_report(8'hFB, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    add_report(8'h02, 16'h0200, 16'hFE00, 16'h0001, 16'h0000);
    build_tx(8'd3, 1'b0, 0);
    check("ts_gyro_len", 64'(tx[0]), 64'd19);
    send_tx(tx.size());
    settle();
    exp_g.push_back(48'h0200_FE00_0001);
    cur_g = 48'h0200_FE00_0001;
    compare_events("ts_gyro");
    check("ts_gyro_qhold", {quat_w, quat_x, quat_y, quat_z}, cur_q);

    // Rotation vector then gyro back to back with no gaps.
    gap_max = 0;
    clear_events();
    pkt.delete();
    add_report(8'h05, 16'h7FFF, 16'h8000, 16'h1234, 16'h4000);
    add_report(8'h02, 16'h0011, 16'hFFEE, 16'h0100, 16'h0000);
    build_tx(8'd3, 1'b0, 0);
    send_tx(tx.size());
    settle();
    exp_q.push_back(64'h4000_7FFF_8000_1234);
    exp_g.push_back(48'h0011_FFEE_0100);
    cur_q = 64'h4000_7FFF_8000_1234;
    cur_g = 48'h0011_FFEE_0100;
    compare_events("two_rpt");
    if (got_q_cyc.size() == 1 && got_g_cyc.size() == 1)
      check("two_rpt_spacing", 64'(got_g_cyc[0] - got_q_cyc[0]), 64'd10);

    // New packet start in the middle of a rotation-vector body.
    gap_max = 1;
    clear_events();
    pkt.delete();
    add_report(8'h05, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    build_tx(8'd3, 1'b0, 0);
    send_tx(10);
    pkt.delete();
    add_report(8'h02, 16'h0303, 16'hFCFC, 16'h0042, 16'h0000);
    build_tx(8'd3, 1'b0, 0);
    send_tx(tx.size());
    settle();
    exp_drop++;
    exp_g.push_back(48'h0303_FCFC_0042);
    cur_g = 48'h0303_FCFC_0042;
    compare_events("mid_first");
    check("mid_first_qhold", {quat_w, quat_x, quat_y, quat_z}, cur_q);

    // Reset asserted on the very edge that would accept the last body byte.
    clear_events();
    pkt.delete();
    add_report(8'h05, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    build_tx(8'd3, 1'b0, 0);
    send_tx(tx.size() - 1);
    rx_byte = tx[tx.size() - 1]; rx_valid = 1'b1; rx_first = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rst_n = 1'b1;
    settle();
    check("rst_mid_quat",  {quat_w, quat_x, quat_y, quat_z}, 64'd0);
    check("rst_mid_gyro",  64'({gyro_x, gyro_y, gyro_z}), 64'd0);
    check("rst_mid_drop",  64'(drop_count), 64'd0);
    check("rst_mid_pulse", 64'(got_q.size() + got_g.size()), 64'd0);
    cur_q = 64'd0;
    cur_g = 48'd0;
    exp_drop = 0;

    // Randomized packets against the reference model.
    for (int p = 0; p < 60; p++) begin
      int nrep, trunc;
      logic [7:0] id, chan;
      logic cont;
      clear_events();
      pkt.delete();
      nrep = int'($urandom_range(3, 1));
      for (int r = 0; r < nrep; r++) begin
        case ($urandom_range(5, 0))
          0:       id = 8'hFB;
          1:       id = 8'h05;
          2:       id = 8'h08;
          3, 4:    id = 8'h02;
          default: id = 8'h11 + 8'($urandom_range(40, 0));
        endcase
        add_report(id, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      chan    = ($urandom_range(5, 0) == 0) ? 8'd2 : 8'd3;
      cont    = ($urandom_range(7, 0) == 0);
      trunc   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(pkt.size(), 1)) : 0;
      gap_max = int'($urandom_range(2, 0));
      build_tx(chan, cont, trunc);
      send_tx(tx.size());
      if ($urandom_range(3, 0) == 0) send_byte(8'($urandom), 1'b0);
      settle();
      model_packet();
      compare_events($sformatf("rnd%0d", p));
    end

    // Saturation: 300 one-byte packets each carrying an unknown report ID.
    clear_events();
    gap_max = 0;
    for (int k = 0; k < 300; k++) begin
      pkt.delete();
      pkt.push_back(8'h11);
      build_tx(8'd3, 1'b0, 0);
      send_tx(tx.size());
      exp_drop++;
    end
    settle();
    check("sat_drop",   64'(drop_count), 64'hFF);
    check("sat_pulses", 64'(got_q.size() + got_g.size()), 64'd0);

    check("hold_between_commits", 64'(hold_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
